// File: rtl/cuenta_unos_param.sv
// Serial bit-population counter.
// A start loads an N-bit operand. The unit then examines one bit per clock and counts the
// 1 bits (modo=0) or the 0 bits (modo=1). fin is raised once the count is final.
// A new start is accepted in IDLE or DONE. Reset is synchronous, active-high, and overrides start.
module cuenta_unos_param #(
  parameter int unsigned N  = 8,
  parameter int unsigned CW = $clog2(N + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [N-1:0]  Valor,
  input  logic          modo,
  output logic [CW-1:0] Cuenta,
  output logic          fin,
  output logic          ocupado
);

  localparam int unsigned IW = (N > 2) ? $clog2(N) : 1;
  localparam logic [IW-1:0] IdxLast = IW'(N - 1);

  typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

  state_e        state_q, state_d;
  logic [N-1:0]  sh_q, sh_d;
  logic          m_q, m_d;
  logic [CW-1:0] cuenta_q, cuenta_d;
  logic [IW-1:0] idx_q, idx_d;

  // Next-state logic: load on an accepted start, then shift one bit per cycle for N cycles.
  always_comb begin
    state_d  = state_q;
    sh_d     = sh_q;
    m_d      = m_q;
    cuenta_d = cuenta_q;
    idx_d    = idx_q;
    case (state_q)
      StIdle, StDone: begin
        if (start) begin
          sh_d     = Valor;
          m_d      = modo;
          cuenta_d = '0;
          idx_d    = '0;
          state_d  = StShift;
        end
      end
      StShift: begin
        // In zero-count mode, m_q=1 inverts the tested bit.
        if (sh_q[0] ^ m_q) begin
          cuenta_d = cuenta_q + CW'(1);
        end
        sh_d  = sh_q >> 1;
        idx_d = idx_q + IW'(1);
        if (idx_q == IdxLast) begin
          state_d = StDone;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State registers with synchronous reset; reset discards any partial count.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StIdle;
      sh_q     <= '0;
      m_q      <= 1'b0;
      cuenta_q <= '0;
      idx_q    <= '0;
    end else begin
      state_q  <= state_d;
      sh_q     <= sh_d;
      m_q      <= m_d;
      cuenta_q <= cuenta_d;
      idx_q    <= idx_d;
    end
  end

  assign Cuenta  = cuenta_q;
  assign fin     = (state_q == StDone);
  assign ocupado = (state_q == StShift);

endmodule

// File: tb/tb_cuenta_unos_param.sv
// Directed bench for cuenta_unos_param.
// It drives one N=8 instance and one N=3 instance. Inputs change and outputs are read 1 ns after
// each rising edge.
module tb_cuenta_unos_param;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic [7:0] valor = '0;
  logic       modo = 1'b0;
  logic [3:0] cuenta;
  logic       fin, ocupado;

  logic       start3 = 1'b0;
  logic [2:0] valor3 = '0;
  logic [1:0] cuenta3;
  logic       fin3, ocupado3;

  int errors = 0;
  int checks = 0;

  always #20 clk = ~clk;

  cuenta_unos_param #(.N(8)) dut8 (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .Valor  (valor),
    .modo   (modo),
    .Cuenta (cuenta),
    .fin    (fin),
    .ocupado(ocupado)
  );

  cuenta_unos_param #(.N(3)) dut3 (
    .clk    (clk),
    .reset  (reset),
    .start  (start3),
    .Valor  (valor3),
    .modo   (1'b0),
    .Cuenta (cuenta3),
    .fin    (fin3),
    .ocupado(ocupado3)
  );

  typedef struct {
    logic [7:0] valor;
    logic       modo;
    logic [3:0] exp;
  } vec_t;

  vec_t vecs[8];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // One full operation on the N=8 instance, starting from IDLE or DONE.
  task automatic run_op(input logic [7:0] v, input logic m, input logic [3:0] exp, input int id);
    valor = v;
    modo  = m;
    start = 1'b1;
    step();                       // E0
    start = 1'b0;
    chk($sformatf("v%0d load ocupado", id), 32'(ocupado), 1);
    chk($sformatf("v%0d load fin", id), 32'(fin), 0);
    chk($sformatf("v%0d load cuenta", id), 32'(cuenta), 0);
    repeat (7) step();            // E0+7
    chk($sformatf("v%0d e7 ocupado", id), 32'(ocupado), 1);
    chk($sformatf("v%0d e7 fin", id), 32'(fin), 0);
    step();                       // E0+8
    chk($sformatf("v%0d fin", id), 32'(fin), 1);
    chk($sformatf("v%0d ocupado", id), 32'(ocupado), 0);
    chk($sformatf("v%0d cuenta", id), 32'(cuenta), 32'(exp));
  endtask

  initial begin
    logic [1:0] pop3 [8];
    pop3 = '{2'd0, 2'd1, 2'd1, 2'd2, 2'd1, 2'd2, 2'd2, 2'd3};

    vecs[0] = '{valor: 8'hA5, modo: 1'b0, exp: 4'd4};
    vecs[1] = '{valor: 8'h00, modo: 1'b0, exp: 4'd0};
    vecs[2] = '{valor: 8'hFF, modo: 1'b0, exp: 4'd8};
    vecs[3] = '{valor: 8'h01, modo: 1'b1, exp: 4'd7};
    vecs[4] = '{valor: 8'hFF, modo: 1'b1, exp: 4'd0};
    vecs[5] = '{valor: 8'h80, modo: 1'b0, exp: 4'd1};
    vecs[6] = '{valor: 8'h3C, modo: 1'b1, exp: 4'd4};
    vecs[7] = '{valor: 8'h00, modo: 1'b1, exp: 4'd8};

    // Reset state after two reset edges.
    step();
    step();
    chk("reset cuenta", 32'(cuenta), 0);
    chk("reset fin", 32'(fin), 0);
    chk("reset ocupado", 32'(ocupado), 0);
    chk("reset cuenta3", 32'(cuenta3), 0);
    reset = 1'b0;
    step();
    chk("idle hold ocupado", 32'(ocupado), 0);
    chk("idle hold fin", 32'(fin), 0);

    // Table vectors. Every vector after the first starts from DONE.
    for (int i = 0; i < 8; i++) begin
      run_op(vecs[i].valor, vecs[i].modo, vecs[i].exp, i);
    end

    // DONE holds its result while start stays low.
    repeat (3) step();
    chk("done hold fin", 32'(fin), 1);
    chk("done hold cuenta", 32'(cuenta), 8);

    // start and Valor changes during SHIFT are ignored.
    valor = 8'h0F;
    modo  = 1'b0;
    start = 1'b1;
    step();                       // E0
    start = 1'b0;
    step();
    step();                       // SHIFT cycle 3
    start = 1'b1;
    valor = 8'hFF;
    step();
    start = 1'b0;
    chk("ignore ocupado", 32'(ocupado), 1);
    repeat (4) step();            // E0+7
    chk("ignore e7 fin", 32'(fin), 0);
    step();                       // E0+8
    chk("ignore fin", 32'(fin), 1);
    chk("ignore cuenta", 32'(cuenta), 4);

    // Restart from DONE: fin drops and ocupado rises on the same edge.
    valor = 8'h80;
    start = 1'b1;
    step();
    start = 1'b0;
    chk("restart fin", 32'(fin), 0);
    chk("restart ocupado", 32'(ocupado), 1);
    repeat (7) step();
    step();
    chk("restart done fin", 32'(fin), 1);
    chk("restart cuenta", 32'(cuenta), 1);

    // Reset aborts a count in progress.
    valor = 8'hFF;
    start = 1'b1;
    step();                       // E0
    start = 1'b0;
    repeat (3) step();            // SHIFT cycle 4
    chk("pre-abort cuenta", 32'(cuenta), 3);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("abort cuenta", 32'(cuenta), 0);
    chk("abort ocupado", 32'(ocupado), 0);
    chk("abort fin", 32'(fin), 0);
    step();
    chk("abort idle ocupado", 32'(ocupado), 0);
    run_op(8'h03, 1'b0, 4'd2, 100);

    // N=3 instance: sweep every operand value.
    for (int v = 0; v < 8; v++) begin
      valor3 = 3'(v);
      start3 = 1'b1;
      step();
      start3 = 1'b0;
      chk($sformatf("n3 v%0d ocupado", v), 32'(ocupado3), 1);
      step();
      step();
      chk($sformatf("n3 v%0d e2 fin", v), 32'(fin3), 0);
      step();
      chk($sformatf("n3 v%0d fin", v), 32'(fin3), 1);
      chk($sformatf("n3 v%0d cuenta", v), 32'(cuenta3), 32'(pop3[v]));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
